// File: rtl/ex1_1_stim_driver.sv
// rtl/ex1_1_stim_driver.sv - burst stimulus source with LFSR data and response predictor
// Drives validi/data_in bursts to the ex1_1 datapath and predicts valido/data_out.
module ex1_1_stim_driver #(
  parameter int            DW        = 32,
  parameter logic [DW-1:0] LFSR_POLY = DW'(32'h80200003)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    run_len,
  input  logic [3:0]    gap_len,
  input  logic [7:0]    num_bursts,
  input  logic [DW-1:0] seed,
  output logic          validi,
  output logic [DW-1:0] data_in,
  output logic          busy,
  output logic          done,
  output logic          exp_valid,
  output logic [DW-1:0] exp_data
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

  state_t        state, state_nxt;
  logic [3:0]    run_q, gap_q, run_cnt, gap_cnt;
  logic [7:0]    num_q, burst_cnt;
  logic [DW-1:0] lfsr, lfsr_nxt, d1, d2;
  logic [1:0]    cnt;
  logic          burst_end, last_burst, gap_end;
  logic          exp_valid_q;
  logic [DW-1:0] exp_data_q;

  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);

  always_comb begin
    state_nxt  = state;
    burst_end  = (run_cnt == run_q - 4'd1);
    last_burst = (burst_cnt == num_q - 8'd1);
    gap_end    = (gap_cnt == gap_q - 4'd1);
    validi     = 1'b0;
    data_in    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    exp_valid  = exp_valid_q;
    exp_data   = exp_data_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (run_len == 4'd0 || num_bursts == 8'd0) state_nxt = FIN;
          else                                        state_nxt = RUN;
        end
      end
      RUN: begin
        validi  = 1'b1;
        data_in = lfsr;
        busy    = 1'b1;
        if (burst_end) begin
          if (last_burst)          state_nxt = FIN;
          else if (gap_q == 4'd0)  state_nxt = RUN;
          else                     state_nxt = GAP;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (gap_end) state_nxt = RUN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run_q       <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      run_cnt     <= '0;
      gap_cnt     <= '0;
      burst_cnt   <= '0;
      lfsr        <= '0;
      d1          <= '0;
      d2          <= '0;
      cnt         <= '0;
      exp_valid_q <= 1'b0;
      exp_data_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            run_q     <= run_len;
            gap_q     <= gap_len;
            num_q     <= num_bursts;
            lfsr      <= (seed == '0) ? DW'(1) : seed;
            run_cnt   <= '0;
            gap_cnt   <= '0;
            burst_cnt <= '0;
          end
        end
        RUN: begin
          lfsr <= lfsr_nxt;
          if (burst_end) begin
            run_cnt <= '0;
            gap_cnt <= '0;
            // With no gap the next burst starts immediately, so count it here
            if (!last_burst && gap_q == 4'd0) burst_cnt <= burst_cnt + 8'd1;
          end else begin
            run_cnt <= run_cnt + 4'd1;
          end
        end
        GAP: begin
          if (gap_end) begin
            gap_cnt   <= '0;
            burst_cnt <= burst_cnt + 8'd1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: ;
      endcase

      // Predictor: a result follows every third-or-later consecutive validi
      if (validi) begin
        d2          <= d1;
        d1          <= lfsr;
        cnt         <= (cnt == 2'd2) ? 2'd2 : cnt + 2'd1;
        exp_valid_q <= (cnt == 2'd2);
        exp_data_q  <= (cnt == 2'd2) ? (d2 * d1 + lfsr) : '0;
      end else begin
        cnt         <= '0;
        exp_valid_q <= 1'b0;
        exp_data_q  <= '0;
      end
    end
  end

endmodule
